// File: rtl/spec_readout_if.sv
// rtl/spec_readout_if.sv - command, DPRAM read and output stream bundle for spec_readout
//
// Groups every non-clock/reset signal of the readout block.
//   slave  : the readout engine (takes start, returns read addresses and the sample stream)
//   master : the surrounding logic (issues start, supplies RAM data, consumes the stream)
interface spec_readout_if #(
  parameter int DW = 32
);
  logic          start;
  logic [4:0]    rangebin_num;
  logic          bg_sub_en;
  logic [13:0]   rdaddr_out;
  logic [9:0]    bg_rdaddr_out;
  logic [DW-1:0] dpram_dout;
  logic [DW-1:0] bg_dout;
  logic [DW-1:0] data_out;
  logic          data_valid_out;
  logic          data_ready_in;
  logic [4:0]    bin_out;
  logic [9:0]    index_out;
  logic          busy;
  logic          readout_done;

  modport slave (
    input  start, rangebin_num, bg_sub_en, dpram_dout, bg_dout, data_ready_in,
    output rdaddr_out, bg_rdaddr_out, data_out, data_valid_out, bin_out, index_out,
           busy, readout_done
  );

  modport master (
    output start, rangebin_num, bg_sub_en, dpram_dout, bg_dout, data_ready_in,
    input  rdaddr_out, bg_rdaddr_out, data_out, data_valid_out, bin_out, index_out,
           busy, readout_done
  );
endinterface

// File: rtl/spec_readout.sv
// rtl/spec_readout.sv - spectrum DPRAM readout with optional background subtraction
//
// Walks range bins 1..rangebin_num and spectral indices 0..1023, reads the
// accumulation DPRAM and the background DPRAM, optionally subtracts the
// background (floored at 0) and streams {data, bin, index} out through a
// small FIFO with valid/ready backpressure.
//   clk, rst        : clock, asynchronous active-high reset
//   bus.start       : one-cycle pulse, rangebin_num/bg_sub_en sampled with it
//   bus.rdaddr_out  : {bin, index} DPRAM read address; bg_rdaddr_out = index
//   bus.dpram_dout  : read data, RD_LAT cycles after the address
//   bus.data_*      : output stream with bin_out/index_out tags
//   bus.busy        : run in progress; readout_done pulses after the last accept
module spec_readout #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int DW         = 32
) (
  input logic           clk,
  input logic           rst,
  spec_readout_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 15;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [4:0]    rb_num_q;
  logic          bg_en_q;
  logic [4:0]    bin_q;
  logic [9:0]    idx_q;
  logic          issue_q;
  logic [13:0]   rdaddr_q;
  logic [9:0]    bg_rdaddr_q;
  logic [RD_LAT-1:0] pipe_v;
  logic [14:0]   pipe_tag [RD_LAT];
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [CW:0]   credit_used;
  logic          accept_start;
  logic          issue, last_read, push, pop, fifo_valid;
  logic [DW-1:0] result;

  // Credits cover both buffered entries and reads still in the RAM pipeline,
  // so the FIFO can never be written while full.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue        = (state == ISSUE) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign last_read    = (bin_q == rb_num_q) && (idx_q == 10'd1023);
  assign accept_start = (state == IDLE) && bus.start && (bus.rangebin_num != 5'd0);

  assign push       = pipe_v[RD_LAT-1];
  assign fifo_valid = (fifo_count != '0);
  assign pop        = fifo_valid && bus.data_ready_in;

  always_comb begin
    result = bus.dpram_dout;
    if (bg_en_q) begin
      result = (bus.dpram_dout >= bus.bg_dout) ? (bus.dpram_dout - bus.bg_dout) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = (bus.rangebin_num != 5'd0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (issue && last_read) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge that pops the last entry so busy drops with it.
        if ((inflight == '0) &&
            ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rb_num_q    <= '0;
      bg_en_q     <= 1'b0;
      bin_q       <= '0;
      idx_q       <= '0;
      issue_q     <= 1'b0;
      rdaddr_q    <= '0;
      bg_rdaddr_q <= '0;
      pipe_v      <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_tag[i] <= '0;
      inflight    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nx;

      if (accept_start) begin
        rb_num_q <= bus.rangebin_num;
        bg_en_q  <= bus.bg_sub_en;
        bin_q    <= 5'd1;
        idx_q    <= 10'd0;
      end else if (issue) begin
        idx_q <= idx_q + 10'd1;
        if (idx_q == 10'd1023) begin
          bin_q <= bin_q + 5'd1;
        end
      end

      issue_q <= issue;
      if (issue) begin
        rdaddr_q    <= {bin_q, idx_q};
        bg_rdaddr_q <= idx_q;
      end

      // Tag pipeline starts from the registered address, so its last stage
      // lines up with the RAM data RD_LAT cycles later.
      pipe_v[0]   <= issue_q;
      pipe_tag[0] <= rdaddr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end

      inflight   <= inflight + CW'(issue) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {result, pipe_tag[RD_LAT-1]};
    end
  end

  assign head = fifo_mem[rd_ptr];

  assign bus.rdaddr_out     = rdaddr_q;
  assign bus.bg_rdaddr_out  = bg_rdaddr_q;
  assign bus.data_valid_out = fifo_valid;
  // Head fields are gated so the stream reads 0 while empty (and under reset).
  assign bus.data_out       = fifo_valid ? head[EW-1:15] : '0;
  assign bus.bin_out        = fifo_valid ? head[14:10]   : '0;
  assign bus.index_out      = fifo_valid ? head[9:0]     : '0;
  assign bus.busy           = (state == ISSUE) || (state == DRAIN);
  assign bus.readout_done   = (state == DONE);
endmodule

// File: tb/tb_spec_readout.sv
// tb/tb_spec_readout.sv - scoreboard bench for spec_readout
module tb_spec_readout;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int DW         = 32;

  logic clk;
  logic rst;
  spec_readout_if #(.DW(DW)) bus();

  spec_readout #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int issued   = 0;
  int accepted = 0;
  int done_cnt = 0;
  int ram_mode = 0;
  logic [13:0] last_rdaddr = '0;
  logic [13:0] exp_addr    = '0;
  logic        stall_q     = 1'b0;
  logic [46:0] held        = '0;
  logic [46:0] exp_q [$];

  // RAM model: mode 0 returns the address, mode 1 returns 1000+index with background 1010.
  logic [13:0] ap [RD_LAT];
  always @(posedge clk) begin
    ap[0] <= bus.rdaddr_out;
    for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
  end
  assign bus.dpram_dout = (ram_mode == 0) ? DW'(ap[RD_LAT-1]) : (DW'(1000) + DW'(ap[RD_LAT-1][9:0]));
  assign bus.bg_dout    = (ram_mode == 0) ? 32'h0000_0100 : 32'd1010;

  function automatic logic [46:0] exp_word(input int mode, input int b, input int i);
    logic [31:0] d;
    if (mode == 0) d = 32'(b * 1024 + i);
    else           d = (i < 10) ? 32'd0 : 32'(i - 10);
    return {d, 5'(b), 10'(i)};
  endfunction

  task automatic load_expected(input int rb, input int mode);
    for (int b = 1; b <= rb; b++)
      for (int i = 0; i < 1024; i++)
        exp_q.push_back(exp_word(mode, b, i));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_rdaddr = '0;
      stall_q     = 1'b0;
    end else begin
      if (bus.rdaddr_out !== last_rdaddr) begin
        issued++;
        last_rdaddr = bus.rdaddr_out;
        n_checks++;
        if ({bus.rdaddr_out, bus.bg_rdaddr_out} !== {exp_addr, exp_addr[9:0]})
          $display("FAIL read_addr got %h/%h want %h/%h", bus.rdaddr_out, bus.bg_rdaddr_out, exp_addr, exp_addr[9:0]);
        else n_pass++;
        n_checks++;
        if (issued - accepted > FIFO_DEPTH)
          $display("FAIL credit_overflow outstanding %0d limit %0d", issued - accepted, FIFO_DEPTH);
        else n_pass++;
        exp_addr = exp_addr + 14'd1;
      end
      if (stall_q) begin
        n_checks++;
        if (!bus.data_valid_out || {bus.data_out, bus.bin_out, bus.index_out} !== held)
          $display("FAIL hold_stable got v=%b %h want v=1 %h", bus.data_valid_out,
                   {bus.data_out, bus.bin_out, bus.index_out}, held);
        else n_pass++;
      end
      if (bus.data_valid_out && bus.data_ready_in) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_sample got bin=%0d idx=%0d data=%h want none", bus.bin_out, bus.index_out, bus.data_out);
        end else begin
          logic [46:0] e;
          e = exp_q.pop_front();
          if ({bus.data_out, bus.bin_out, bus.index_out} !== e)
            $display("FAIL sample got bin=%0d idx=%0d data=%h want bin=%0d idx=%0d data=%h",
                     bus.bin_out, bus.index_out, bus.data_out, e[14:10], e[9:0], e[46:15]);
          else n_pass++;
        end
        accepted++;
      end
      stall_q = bus.data_valid_out && !bus.data_ready_in;
      held    = {bus.data_out, bus.bin_out, bus.index_out};
      if (bus.readout_done) begin
        done_cnt++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL done_early got %0d pending want 0", exp_q.size());
        else n_pass++;
      end
    end
  end

  task automatic pulse_start(input logic [4:0] rb, input logic bg);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.rangebin_num = rb; bus.bg_sub_en = bg;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, output bit ok);
    int c, d0;
    d0 = done_cnt; c = 0;
    while (done_cnt == d0 && c < 20000) begin
      @(posedge clk); #1;
      if (rnd) bus.data_ready_in = 1'($urandom_range(0, 1));
      c++;
    end
    ok = (done_cnt != d0);
    bus.data_ready_in = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.rdaddr_out, bus.bg_rdaddr_out, bus.data_out, bus.data_valid_out, bus.bin_out,
         bus.index_out, bus.busy, bus.readout_done} !== '0)
      $display("FAIL reset_outputs got addr=%h bg=%h data=%h v=%b busy=%b done=%b want 0", bus.rdaddr_out,
               bus.bg_rdaddr_out, bus.data_out, bus.data_valid_out, bus.busy, bus.readout_done);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_bin;
    int a0, d0, c;
    bus.data_ready_in = 1'b1; ram_mode = 0;
    load_expected(1, 0); exp_addr = 14'h400;
    a0 = accepted; d0 = done_cnt;
    pulse_start(5'd1, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL busy_after_start got %b want 1", bus.busy);
    else n_pass++;
    c = 0;
    while (!bus.data_valid_out && c < 50) begin @(posedge clk); #1; c++; end
    n_checks++;
    if (c != 2 + RD_LAT) $display("FAIL first_valid_latency got %0d want %0d", c, 2 + RD_LAT);
    else n_pass++;
    c = 0;
    while (accepted - a0 < 1024 && c < 5000) begin @(negedge clk); #1; c++; end
    n_checks++;
    if (c != 1024) $display("FAIL stream_continuous got %0d cycles want 1024", c);
    else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL single_done_count got %0d want 1", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (accepted - a0 != 1024 || exp_q.size() != 0)
      $display("FAIL single_total got %0d pending %0d want 1024 pending 0", accepted - a0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bg_sub;
    int a0, d0; bit ok;
    bus.data_ready_in = 1'b1; ram_mode = 1;
    load_expected(3, 1); exp_addr = 14'h400;
    a0 = accepted; d0 = done_cnt;
    pulse_start(5'd3, 1'b1);
    wait_done(1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL bg_done_timeout got none want done");
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (accepted - a0 != 3072 || done_cnt - d0 != 1 || exp_q.size() != 0)
      $display("FAIL bg_total got %0d done %0d want 3072 done 1", accepted - a0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_random_ready;
    int a0, d0; bit ok;
    ram_mode = 0;
    load_expected(2, 0); exp_addr = 14'h400;
    a0 = accepted; d0 = done_cnt;
    pulse_start(5'd2, 1'b0);
    wait_done(1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL random_done_timeout got none want done");
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (accepted - a0 != 2048 || done_cnt - d0 != 1 || exp_q.size() != 0)
      $display("FAIL random_total got %0d done %0d want 2048 done 1", accepted - a0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_stall;
    int a0, i0; bit ok;
    bus.data_ready_in = 1'b0; ram_mode = 0;
    load_expected(1, 0); exp_addr = 14'h400;
    a0 = accepted; i0 = issued;
    pulse_start(5'd1, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (issued - i0 != FIFO_DEPTH) $display("FAIL stall_reads got %0d want %0d", issued - i0, FIFO_DEPTH);
    else n_pass++;
    n_checks++;
    if (bus.rdaddr_out !== 14'(16'h400 + FIFO_DEPTH - 1))
      $display("FAIL stall_addr got %h want %h", bus.rdaddr_out, 14'(16'h400 + FIFO_DEPTH - 1));
    else n_pass++;
    n_checks++;
    if (bus.data_valid_out !== 1'b1 || bus.data_out !== 32'h400)
      $display("FAIL stall_head got v=%b %h want v=1 00000400", bus.data_valid_out, bus.data_out);
    else n_pass++;
    bus.data_ready_in = 1'b1;
    wait_done(1'b0, ok);
    n_checks++;
    if (!ok || accepted - a0 != 1024 || exp_q.size() != 0)
      $display("FAIL stall_resume got %0d pending %0d want 1024 pending 0", accepted - a0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_start_busy;
    int a0, d0; bit ok;
    bus.data_ready_in = 1'b1; ram_mode = 0;
    load_expected(1, 0); exp_addr = 14'h400;
    a0 = accepted; d0 = done_cnt;
    pulse_start(5'd1, 1'b0);
    repeat (50) @(posedge clk);
    pulse_start(5'd3, 1'b1);
    wait_done(1'b0, ok);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || accepted - a0 != 1024 || done_cnt - d0 != 1 || exp_q.size() != 0)
      $display("FAIL start_while_busy got %0d done %0d want 1024 done 1", accepted - a0, done_cnt - d0);
    else n_pass++;
    a0 = accepted; d0 = done_cnt;
    pulse_start(5'd0, 1'b0);
    n_checks++;
    if (bus.readout_done !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL zero_bin_done got done=%b busy=%b want done=1 busy=0", bus.readout_done, bus.busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.readout_done !== 1'b0 || bus.data_valid_out !== 1'b0)
      $display("FAIL zero_bin_after got done=%b v=%b want 0 0", bus.readout_done, bus.data_valid_out);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1 || accepted != a0)
      $display("FAIL zero_bin_total got done %0d samples %0d want 1 0", done_cnt - d0, accepted - a0);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int c, d0;
    bus.data_ready_in = 1'b1; ram_mode = 0;
    load_expected(3, 0); exp_addr = 14'h400;
    d0 = done_cnt;
    pulse_start(5'd3, 1'b0);
    c = 0;
    while (!(bus.data_valid_out && bus.bin_out == 5'd2 && bus.index_out == 10'd500) && c < 5000) begin
      @(negedge clk); #1; c++;
    end
    n_checks++;
    if (c >= 5000) $display("FAIL reach_bin2_idx500 got bin=%0d idx=%0d want 2/500", bus.bin_out, bus.index_out);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.rdaddr_out, bus.bg_rdaddr_out, bus.data_out, bus.data_valid_out, bus.bin_out,
         bus.index_out, bus.busy, bus.readout_done} !== '0)
      $display("FAIL mid_reset_outputs got addr=%h data=%h v=%b busy=%b want 0", bus.rdaddr_out,
               bus.data_out, bus.data_valid_out, bus.busy);
    else n_pass++;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0 || bus.readout_done !== 1'b0)
      $display("FAIL mid_reset_no_done got %0d want 0", done_cnt - d0);
    else n_pass++;
    @(negedge clk); #1;
    rst = 1'b0;
    test_single_bin();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.rangebin_num = '0;
    bus.bg_sub_en = 1'b0;
    bus.data_ready_in = 1'b1;
    test_reset();
    test_single_bin();
    test_bg_sub();
    test_random_ready();
    test_stall();
    test_start_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spec_readout.md
Name: spec_readout

Overview:
- Reader side of the spectrum-accumulation DPRAM.
- Once accumulation finishes, it walks the stored accumulated spectra for range bins 1..N and indices 0..1023, generating DPRAM and background-DPRAM read addresses.
- Optionally subtracts the background spectrum, with saturation at 0.
- Streams the result out on a valid/ready interface toward the upload/host path, with full backpressure support.

Parameters:
- RD_LAT, 2, DPRAM read latency in cycles from address presented to data valid (1..4).
- FIFO_DEPTH, 8, output buffer depth (power of 2; must be >= RD_LAT+2).
- DW, 32, accumulated data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a readout (driven from the accumulation-done pulse).
- rangebin_num  in  5  number of range bins to read (0..31), sampled at start.
- bg_sub_en  in  1  background subtraction enable, sampled at start.
- rdaddr_out  out  14  DPRAM read address {bin[4:0], index[9:0]}.
- bg_rdaddr_out  out  10  DPRAM_BG read address (index only).
- dpram_dout  in  DW  DPRAM read data, valid RD_LAT cycles after rdaddr_out.
- bg_dout  in  DW  DPRAM_BG read data, same latency.
- data_out  out  DW  output sample.
- data_valid_out  out  1  output valid.
- data_ready_in  in  1  downstream ready.
- bin_out  out  5  range bin of the current data_out.
- index_out  out  10  spectral index of the current data_out.
- busy  out  1  high from the start acceptance edge until the last sample has been accepted.
- readout_done  out  1  one-cycle pulse after the last sample has been accepted.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, in-flight count 0.
- Reset mid-operation aborts immediately; no done pulse is issued.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with rangebin_num>0 latches rangebin_num and bg_sub_en, sets bin=1, index=0, busy=1, then goes to ISSUE.
  - start=1 with rangebin_num=0 goes straight to DONE; busy stays 0.
  - start while not in IDLE is ignored.
- ISSUE:
  - A read is issued in a cycle only if fifo_count + inflight < FIFO_DEPTH.
  - On a read: rdaddr_out <= {bin, index}, bg_rdaddr_out <= index (registered), and the tag {bin, index} is pushed into an RD_LAT-deep tag/valid pipeline.
  - Index increments 0..1023; at 1023 it wraps to 0 and bin increments.
  - The read at {rangebin_num, 1023} is the last; the FSM then goes to DRAIN.
  - With no backpressure, one read issues every cycle.
- Address timing:
  - start sampled at edge k gives the first address on rdaddr_out after edge k+1.
  - Data for an address appears RD_LAT cycles later and is written into the FIFO on the following edge.
- Data path:
  - FIFO entry = {result, bin, index}.
  - With bg_sub_en=1, result = (dpram_dout >= bg_dout) ? dpram_dout - bg_dout : 0 (unsigned, saturating). Otherwise result = dpram_dout.
- Output:
  - data_valid_out = FIFO not empty, and data_out/bin_out/index_out reflect the FIFO head.
  - A pop occurs when data_valid_out && data_ready_in.
  - Output data is held stable while valid=1 and ready=0.
  - Simultaneous push and pop in the same cycle leaves the count unchanged.
- Overflow is impossible by construction because reads are credit-gated. The bench asserts this.
- DRAIN: waits until inflight=0 and the FIFO is empty, then goes to DONE.
- DONE: readout_done=1 for one cycle, busy=0, return to IDLE.
- Total output per run = rangebin_num × 1024 samples, in bin-major, index-ascending order, with no gaps or duplicates.

Test Plan:
- rangebin_num=1, bg_sub_en=0, ready held 1, RAM model returns the address value:
  - 1024 samples with data_out = 0x0400 | i;
  - first data_valid_out 2+RD_LAT cycles after the start edge, then continuous;
  - readout_done exactly once.
- rangebin_num=3, bg_sub_en=1, dpram=1000+i, bg=1010:
  - i<10 gives 0 (saturation);
  - i>=10 gives i-10;
  - bin_out steps 1→2→3 with index_out wrapping 1023→0;
  - 3072 samples total.
- Random ready toggling (~50%), rangebin_num=2:
  - output sequence identical to the ready=1 run;
  - data held stable while stalled;
  - FIFO never overflows;
  - readout_done only after the last accept.
- Ready held 0 for 100 cycles after start:
  - exactly FIFO_DEPTH reads are issued, then rdaddr_out freezes;
  - on release the stream resumes with no loss.
- start while busy, and start with rangebin_num=0:
  - the first is ignored (sequence unaffected);
  - the second gives readout_done one cycle later with no valid outputs.
- rst asserted mid-readout (bin 2, index 500):
  - all outputs 0 immediately;
  - no done pulse;
  - a subsequent start runs a full, correct readout.
